// File: rtl/sram_axi_slave.sv
// AXI4 responder in front of a single-port 32-bit SRAM macro (active-low CEB/WEB/BWEB).
// One transaction in flight; every AXI beat becomes exactly one SRAM access.
module sram_axi_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   i_ARID,
    input  logic [31:0]       i_ARADDR,
    input  logic [3:0]        i_ARLEN,
    input  logic [2:0]        i_ARSIZE,
    input  logic [1:0]        i_ARBURST,
    input  logic              i_ARVALID,
    output logic              o_ARREADY,
    output logic [ID_W-1:0]   o_RID,
    output logic [31:0]       o_RDATA,
    output logic [1:0]        o_RRESP,
    output logic              o_RLAST,
    output logic              o_RVALID,
    input  logic              i_RREADY,
    input  logic [ID_W-1:0]   i_AWID,
    input  logic [31:0]       i_AWADDR,
    input  logic [3:0]        i_AWLEN,
    input  logic [2:0]        i_AWSIZE,
    input  logic [1:0]        i_AWBURST,
    input  logic              i_AWVALID,
    output logic              o_AWREADY,
    input  logic [31:0]       i_WDATA,
    input  logic [3:0]        i_WSTRB,
    input  logic              i_WLAST,
    input  logic              i_WVALID,
    output logic              o_WREADY,
    output logic [ID_W-1:0]   o_BID,
    output logic [1:0]        o_BRESP,
    output logic              o_BVALID,
    input  logic              i_BREADY,
    output logic              o_CEB,
    output logic              o_WEB,
    output logic [31:0]       o_BWEB,
    output logic [ADDR_W-1:0] o_A,
    output logic [31:0]       o_DI,
    input  logic [31:0]       i_DO
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t            r_state;
    logic              r_arready;
    logic              r_rvalid;
    logic              r_wready;
    logic              r_bvalid;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_idx;
    logic [3:0]        r_len;
    logic [1:0]        r_burst;
    logic [3:0]        r_beat;

    logic              w_rlast;
    logic              w_rdActive;
    logic              w_wrActive;
    logic [ADDR_W-1:0] w_nextIdx;
    logic [31:0]       w_bweb;
    logic              w_unused;

    // Size, write length and out-of-range address bits carry no meaning for this SRAM.
    assign w_unused = &{i_ARSIZE, i_AWSIZE, i_AWLEN,
                        i_ARADDR[31:ADDR_W+2], i_ARADDR[1:0],
                        i_AWADDR[31:ADDR_W+2], i_AWADDR[1:0]};

    assign w_rlast    = r_rvalid && (r_beat == r_len);
    assign w_rdActive = (r_state == RD_REQ);
    assign w_wrActive = r_wready && i_WVALID;
    assign w_nextIdx  = (r_burst == 2'b00) ? r_idx : r_idx + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_id      <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Read has priority: AWREADY is masked whenever ARVALID is high.
                    if (i_ARVALID) begin
                        r_id      <= i_ARID;
                        r_idx     <= i_ARADDR[ADDR_W+1:2];
                        r_len     <= i_ARLEN;
                        r_burst   <= i_ARBURST;
                        r_beat    <= '0;
                        r_arready <= 1'b0;
                        r_state   <= RD_REQ;
                    end else if (i_AWVALID) begin
                        r_id      <= i_AWID;
                        r_idx     <= i_AWADDR[ADDR_W+1:2];
                        r_burst   <= i_AWBURST;
                        r_arready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_state   <= WR_DATA;
                    end
                end
                RD_REQ: begin
                    r_rvalid <= 1'b1;
                    r_state  <= RD_RESP;
                end
                RD_RESP: begin
                    if (i_RREADY) begin
                        r_rvalid <= 1'b0;
                        if (w_rlast) begin
                            r_arready <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_beat  <= r_beat + 4'd1;
                            r_idx   <= w_nextIdx;
                            r_state <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (i_WVALID) begin
                        r_idx <= w_nextIdx;
                        if (i_WLAST) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (i_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Byte strobes expand to active-low bit enables; idle value is all ones.
    always_comb begin
        w_bweb = '1;
        if (w_wrActive) begin
            for (int k = 0; k < 4; k++) begin
                w_bweb[8*k +: 8] = {8{~i_WSTRB[k]}};
            end
        end
    end

    assign o_ARREADY = r_arready;
    assign o_AWREADY = r_arready && !i_ARVALID;
    assign o_RVALID  = r_rvalid;
    assign o_RDATA   = i_DO;
    assign o_RID     = r_id;
    assign o_RRESP   = 2'b00;
    assign o_RLAST   = w_rlast;
    assign o_WREADY  = r_wready;
    assign o_BVALID  = r_bvalid;
    assign o_BID     = r_id;
    assign o_BRESP   = 2'b00;

    assign o_CEB  = !(w_rdActive || w_wrActive);
    assign o_WEB  = !w_wrActive;
    assign o_BWEB = w_bweb;
    assign o_A    = (w_rdActive || w_wrActive) ? r_idx : '0;
    assign o_DI   = w_wrActive ? i_WDATA : 32'h0;

endmodule
